pipelined_dot2: RTL and testbench



---
 rtl/pipelined_dot2.sv | 51 +++++
 tb/tb_pipelined_dot2.sv | 118 +++++++++++
 2 files changed

// File: rtl/pipelined_dot2.sv
// pipelined_dot2: 3-stage C = A1*B1 + A2*B2 mod 2^WIDTH; defining PIPELINE_VALID_EN adds in_valid/out_valid
module pipelined_dot2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] B2,
`ifdef PIPELINE_VALID_EN
    input  logic             in_valid,
    output logic             out_valid,
`endif
    output logic [WIDTH-1:0] C
);
    logic [WIDTH-1:0] s1_a1, s1_b1, s1_a2, s1_b2, p1, p2;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_a1 <= '0;
            s1_b1 <= '0;
            s1_a2 <= '0;
            s1_b2 <= '0;
            p1    <= '0;
            p2    <= '0;
            C     <= '0;
        end else begin
            s1_a1 <= A1;
            s1_b1 <= B1;
            s1_a2 <= A2;
            s1_b2 <= B2;
            p1    <= s1_a1 * s1_b1;
            p2    <= s1_a2 * s1_b2;
            C     <= p1 + p2;
        end
    end
`ifdef PIPELINE_VALID_EN
    logic v1, v2;
    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
        end
    end
`endif
endmodule

// File: tb/tb_pipelined_dot2.sv
// tb_pipelined_dot2: directed table plus randomized run against a history-based reference model
module tb_pipelined_dot2;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A1 = '0, B1 = '0, A2 = '0, B2 = '0;
    logic [31:0] C;
    logic        in_valid = 1'b0;
`ifdef PIPELINE_VALID_EN
    logic        out_valid;
`endif
    int checks = 0;
    int errors = 0;
    logic [31:0] hd[$];
    bit          hr[$];
    bit          hv[$];

    typedef struct {
        logic [31:0] a1, b1, a2, b2;
        bit          v;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[6];

    pipelined_dot2 #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .A1(A1),
        .B1(B1),
        .A2(A2),
        .B2(B2),
`ifdef PIPELINE_VALID_EN
        .in_valid(in_valid),
        .out_valid(out_valid),
`endif
        .C(C)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dot(input logic [31:0] a, b, c, d);
        longint unsigned s;
        s = (longint'(a) * longint'(b)) % 64'h1_0000_0000 + (longint'(c) * longint'(d)) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    // One clock: apply inputs, then C after this edge reflects the set from two edges back unless a reset edge intervened.
    task automatic cyc(input bit r, input logic [31:0] a, b, c, d, input bit v, input logic [31:0] e, input string n);
        bit z;
        reset = r;
        A1 = a;
        B1 = b;
        A2 = c;
        B2 = d;
        in_valid = v;
        @(posedge clk);
        hd.push_back(e);
        hr.push_back(r);
        hv.push_back(v);
        if (hd.size() > 3) begin
            void'(hd.pop_front());
            void'(hr.pop_front());
            void'(hv.pop_front());
        end
        #1;
        if (r || hd.size() == 3) begin
            z = 1'b0;
            foreach (hr[i]) z |= hr[i];
            check(n, C, z ? 32'd0 : hd[0]);
`ifdef PIPELINE_VALID_EN
            check({n, "_valid"}, {31'd0, out_valid}, z ? 32'd0 : {31'd0, hv[0]});
`endif
        end
    endtask

    task automatic rnd(input bit r, input string n);
        logic [31:0] a, b, c, d;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        d = $urandom;
        cyc(r, a, b, c, d, 1'($urandom_range(0, 1)), dot(a, b, c, d), n);
    endtask

    initial begin
        vecs[0] = '{32'd0, 32'd1, 32'd2, 32'd3, 1'b1, 32'd6};
        vecs[1] = '{32'd3, 32'd0, 32'd1, 32'd3, 1'b0, 32'd3};
        vecs[2] = '{32'hFFFFFFFF, 32'd2, 32'd1, 32'd3, 1'b1, 32'h00000001};
        vecs[3] = '{32'h00010000, 32'h00010000, 32'd0, 32'd0, 1'b1, 32'd0};
        vecs[4] = '{32'd5, 32'd7, 32'd11, 32'd13, 1'b0, 32'd178};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd2};
        rnd(1'b1, "reset0");
        rnd(1'b1, "reset1");
        for (int i = 0; i < 6; i++)
            cyc(1'b0, vecs[i].a1, vecs[i].b1, vecs[i].a2, vecs[i].b2, vecs[i].v, vecs[i].exp, $sformatf("vec%0d", i));
        rnd(1'b0, "flush0");
        rnd(1'b0, "flush1");
        rnd(1'b0, "inflight0");
        rnd(1'b0, "inflight1");
        rnd(1'b0, "inflight2");
        rnd(1'b1, "midreset");
        cyc(1'b0, 32'd4, 32'd5, 32'd6, 32'd7, 1'b1, 32'd62, "post0");
        rnd(1'b0, "post1");
        rnd(1'b0, "post2");
        rnd(1'b0, "post3");
        for (int i = 0; i < 300; i++)
            rnd($urandom_range(0, 19) == 0, "random");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
